// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key codes used by the screen modules,
// and the prefix-decoder state type.
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_OVF0   = 8'h00;
   localparam logic [7:0] SC_OVF1   = 8'hFF;

   localparam logic [8:0] KEY_SCOLON = 9'h04C;
   localparam logic [8:0] KEY_ENTER  = 9'h05A;
   localparam logic [8:0] KEY_ESC    = 9'h076;
   localparam logic [8:0] KEY_SPACE  = 9'h029;
   localparam logic [8:0] KEY_UP     = 9'h175;
   localparam logic [8:0] KEY_DN     = 9'h172;
   localparam logic [8:0] KEY_LEFT   = 9'h16B;
   localparam logic [8:0] KEY_RIGHT  = 9'h174;

   // Bytes following E1 in the Pause make sequence, all discarded.
   localparam int PAUSE_SKIP = 7;

   typedef enum logic {IDLE, SKIP} pfx_state_t;

   // Controller/status bytes that never carry a key when no prefix is pending.
   function automatic logic is_noise(input logic [7:0] b);
      return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
             (b == SC_ECHO) || (b == SC_OVF0) || (b == SC_OVF1);
   endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 serial byte receiver: input synchronizers, ps2_clk glitch filter,
// 11-bit frame capture with start/parity/stop check and mid-frame timeout.
module ps2_byte_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt_clk;
   logic          filt_clk_d;
   logic [FW-1:0] filt_cnt;
   logic [10:0]   shift_reg;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] idle_cnt;
   logic          fall;
   logic [10:0]   frame;

   function automatic logic frame_ok(input logic [10:0] f);
      return (f[0] == 1'b0) && (^f[9:1] == 1'b1) && (f[10] == 1'b1);
   endfunction

   assign fall  = filt_clk_d & ~filt_clk;
   // Bits arrive LSB first, so the newest bit enters at the top.
   assign frame = {data_sync[1], shift_reg[10:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync   <= '0;
         data_sync  <= '0;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         idle_cnt   <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         filt_clk_d <= filt_clk;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end

         if (fall) begin
            shift_reg <= frame;
            idle_cnt  <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (frame_ok(frame)) begin
                  byte_valid <= 1'b1;
                  rx_byte    <= frame[8:1];
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled partial frame is dropped silently.
            if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard front end: byte receiver plus E0/F0/E1 prefix FSM producing
// key events (last_change/last_down/key_valid) and a held-key bitmap.
module ps2_keyboard_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN    = 8,
   parameter int TIMEOUT_CYC   = 100000,
   parameter int REPORT_REPEAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic         key_valid,
   output logic [8:0]   last_change,
   output logic         last_down,
   output logic [511:0] key_down,
   output logic         frame_err
);

   logic [7:0] rx_byte;
   logic       byte_valid;

   pfx_state_t state, state_nxt;
   logic [2:0] skip_cnt, skip_nxt;
   logic       ext, ext_nxt;
   logic       brk, brk_nxt;
   logic [8:0] code;
   logic       key_we;
   logic       key_set;
   logic       report;

   ps2_byte_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign code = {ext, rx_byte};

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      ext_nxt   = ext;
      brk_nxt   = brk;
      key_we    = 1'b0;
      key_set   = 1'b0;
      report    = 1'b0;
      if (byte_valid) begin
         case (state)
            IDLE: begin
               if (rx_byte == SC_EXT) begin
                  ext_nxt = 1'b1;
               end else if (rx_byte == SC_BRK) begin
                  brk_nxt = 1'b1;
               end else if (rx_byte == SC_PAUSE) begin
                  state_nxt = SKIP;
                  skip_nxt  = '0;
                  ext_nxt   = 1'b0;
                  brk_nxt   = 1'b0;
               end else if (!ext && !brk && is_noise(rx_byte)) begin
                  state_nxt = IDLE;
               end else begin
                  key_we  = 1'b1;
                  key_set = ~brk;
                  ext_nxt = 1'b0;
                  brk_nxt = 1'b0;
                  // Typematic repeats of a held key are dropped unless asked for.
                  report  = brk | ~key_down[code] | (REPORT_REPEAT != 0);
               end
            end
            SKIP: begin
               if (skip_cnt == 3'(PAUSE_SKIP - 1)) begin
                  state_nxt = IDLE;
                  skip_nxt  = '0;
               end else begin
                  skip_nxt = skip_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         skip_cnt    <= '0;
         ext         <= 1'b0;
         brk         <= 1'b0;
         key_down    <= '0;
         key_valid   <= 1'b0;
         last_change <= '0;
         last_down   <= 1'b0;
      end else begin
         state     <= state_nxt;
         skip_cnt  <= skip_nxt;
         ext       <= ext_nxt;
         brk       <= brk_nxt;
         key_valid <= report;
         if (report) begin
            last_change <= code;
            last_down   <= key_set;
         end
         if (key_we) begin
            key_down[code] <= key_set;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench: drives PS/2 frames into two decoders (repeat off/on) and
// checks key events against a queue of expected {last_down, last_change}.
module tb_ps2_keyboard_decoder;

   localparam int HALF = 20;   // half bit period in clk cycles
   localparam int TMO  = 500;  // shortened frame timeout

   logic clk = 1'b0;
   logic rst_n;
   logic ps2_clk;
   logic ps2_data;

   logic         kv0, ld0, fe0;
   logic [8:0]   lc0;
   logic [511:0] kd0;
   logic         kv1, ld1, fe1;
   logic [8:0]   lc1;
   logic [511:0] kd1;

   always #5 clk = ~clk;

   ps2_keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .REPORT_REPEAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_valid(kv0), .last_change(lc0), .last_down(ld0), .key_down(kd0), .frame_err(fe0)
   );

   ps2_keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .REPORT_REPEAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_valid(kv1), .last_change(lc1), .last_down(ld1), .key_down(kd1), .frame_err(fe1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int kv_cyc = 0;
   int stop_cyc = 0;
   int err_cnt0 = 0;
   int kv_cnt1 = 0;
   logic [9:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every dut0 key_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (fe0) err_cnt0++;
      if (kv1) kv_cnt1++;
      if (kv0) begin
         logic [9:0] e;
         kv_cyc = cyc;
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_event obs=%h required=none", {ld0, lc0});
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert ({ld0, lc0} === e) else begin
               bad++;
               $error("FAIL event obs=%h required=%h", {ld0, lc0}, e);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s obs=%0h required=%0h", tag, obs, req);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_neg(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         wait_neg(HALF);
         ps2_clk = 1'b1;
      end
      wait_neg(2 * HALF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk(b), 11);
   endtask

   task automatic expect_ev(input logic down, input logic [8:0] code);
      exp_q.push_back({down, code});
   endtask

   initial begin
      logic [511:0] snap;
      int c1, e0;
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      wait_neg(5);
      check("rst_key_valid", 32'(kv0), 32'd0);
      check("rst_last_change", 32'(lc0), 32'd0);
      check("rst_last_down", 32'(ld0), 32'd0);
      check("rst_frame_err", 32'(fe0), 32'd0);
      total++;
      assert (kd0 === '0) else begin bad++; $error("FAIL rst_key_down obs=nonzero required=0"); end
      rst_n = 1'b1;
      wait_neg(5);

      // Press 4C; 2 sync + 8 filter + rx + decode stages after the raw stop edge.
      expect_ev(1'b1, 9'h04C);
      send_byte(8'h4C);
      check("latency", 32'(kv_cyc - stop_cyc), 32'd12);
      check("kd_4c_make", 32'(kd0[76]), 32'd1);

      expect_ev(1'b0, 9'h04C);
      send_byte(8'hF0); send_byte(8'h4C);
      check("kd_4c_break", 32'(kd0[76]), 32'd0);

      expect_ev(1'b1, 9'h175);
      send_byte(8'hE0); send_byte(8'h75);
      check("kd_175_make", 32'(kd0[373]), 32'd1);
      expect_ev(1'b0, 9'h175);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check("kd_175_break", 32'(kd0[373]), 32'd0);
      expect_ev(1'b1, 9'h01C);
      send_byte(8'h1C);
      check("kd_1c_make", 32'(kd0[28]), 32'd1);
      expect_ev(1'b0, 9'h01C);
      send_byte(8'hF0); send_byte(8'h1C);

      c1 = kv_cnt1;
      expect_ev(1'b1, 9'h04C);
      send_byte(8'h4C); send_byte(8'h4C);
      check("repeat_pulses_dut1", 32'(kv_cnt1 - c1), 32'd2);
      check("kd_4c_repeat", 32'(kd0[76]), 32'd1);
      expect_ev(1'b0, 9'h04C);
      send_byte(8'hF0); send_byte(8'h4C);

      // Bad parity, then bad stop bit.
      snap = kd0;
      e0 = err_cnt0;
      send_bits(mk(8'h1C) ^ 11'h200, 11);
      send_bits(mk(8'h1C) & 11'h3FF, 11);
      check("frame_err_count", 32'(err_cnt0 - e0), 32'd2);
      total++;
      assert (kd0 === snap) else begin bad++; $error("FAIL kd_after_err obs=changed required=unchanged"); end
      expect_ev(1'b1, 9'h01C);
      send_byte(8'h1C);

      // Partial frame abandoned by timeout.
      e0 = err_cnt0;
      send_bits(mk(8'h33), 5);
      wait_neg(TMO + 100);
      expect_ev(1'b1, 9'h04C);
      send_byte(8'h4C);
      check("timeout_no_err", 32'(err_cnt0 - e0), 32'd0);
      check("kd_4c_after_tmo", 32'(kd0[76]), 32'd1);

      // Short ps2_clk glitch must not register as a bit.
      ps2_clk = 1'b0;
      wait_neg(4);
      ps2_clk = 1'b1;
      wait_neg(HALF);
      expect_ev(1'b0, 9'h04C);
      send_byte(8'hF0); send_byte(8'h4C);

      // Status byte and Pause sequence produce nothing.
      snap = kd0;
      send_byte(8'hAA);
      for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
      total++;
      assert (kd0 === snap) else begin bad++; $error("FAIL kd_after_pause obs=changed required=unchanged"); end
      expect_ev(1'b1, 9'h02D);
      send_byte(8'h2D);
      check("kd_2d_make", 32'(kd0[45]), 32'd1);

      // Reset in the middle of a frame.
      send_bits(mk(8'h4C), 5);
      rst_n = 1'b0;
      wait_neg(3);
      total++;
      assert (kd0 === '0) else begin bad++; $error("FAIL midrst_key_down obs=nonzero required=0"); end
      check("midrst_last_change", 32'(lc0), 32'd0);
      check("midrst_last_down", 32'(ld0), 32'd0);
      check("midrst_key_valid", 32'(kv0), 32'd0);
      rst_n = 1'b1;
      wait_neg(5);
      expect_ev(1'b1, 9'h04C);
      send_byte(8'h4C);
      check("kd_4c_after_rst", 32'(kd0[76]), 32'd1);

      wait_neg(20);
      check("pending_events", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog obs=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
